sram_1rw_rr_arbiter: RTL



---
 rtl/sram_1rw_rr_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/sram_1rw_rr_arbiter.sv
// Round-robin arbiter sharing one 1RW SRAM port between NUM_REQ requesters, with in-order read return.
// Optional performance counters are enabled by defining SRAM_ARB_PERF_CNT_EN.
module sram_1rw_rr_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int ADDR_WIDTH   = 11,
   parameter int DATA_WIDTH   = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic                          clk0,
   input  logic                          rst0,
   input  logic [NUM_REQ-1:0]            req_valid,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic [NUM_REQ-1:0]            req_we,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_rdata,
   output logic                          sram_csb0,
   output logic                          sram_web0,
   output logic [ADDR_WIDTH-1:0]         sram_addr0,
   output logic [DATA_WIDTH-1:0]         sram_din0,
   input  logic [DATA_WIDTH-1:0]         sram_dout0
`ifdef SRAM_ARB_PERF_CNT_EN
   ,
   output logic [31:0]                   perf_grant_cnt,
   output logic [31:0]                   perf_conflict_cnt
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [PTR_W-1:0]      ptr;
   logic [PTR_W-1:0]      cand;
   logic [PTR_W-1:0]      grant_id;
   logic                  grant_any;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [READ_LATENCY:0] pipe_valid;
   logic [PTR_W-1:0]      pipe_id [0:READ_LATENCY];

   function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return sum[PTR_W-1:0];
   endfunction

   // Scan from ptr upward (mod NUM_REQ); reset masks grants so nothing is accepted while held.
   always_comb begin
      req_ready = '0;
      grant_any = 1'b0;
      grant_id  = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = wrap_add(ptr, k);
         if (!grant_any && req_valid[cand]) begin
            grant_any = 1'b1;
            grant_id  = cand;
         end
      end
      if (rst0) grant_any = 1'b0;
      if (grant_any) req_ready[grant_id] = 1'b1;
   end

   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_ready[i]) begin
            sel_we    = req_we[i];
            sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         ptr <= '0;
      end else if (grant_any) begin
         ptr <= wrap_add(grant_id, 1);
      end
   end

   // Write data is only reloaded on writes so reads leave din0 untouched.
   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         sram_csb0  <= 1'b1;
         sram_web0  <= 1'b1;
         sram_addr0 <= '0;
         sram_din0  <= '0;
      end else if (grant_any) begin
         sram_csb0  <= 1'b0;
         sram_web0  <= ~sel_we;
         sram_addr0 <= sel_addr;
         if (sel_we) sram_din0 <= sel_wdata;
      end else begin
         sram_csb0 <= 1'b1;
         sram_web0 <= 1'b1;
      end
   end

   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         pipe_valid <= '0;
         for (int s = 0; s <= READ_LATENCY; s++) pipe_id[s] <= '0;
      end else begin
         pipe_valid[0] <= grant_any & ~sel_we;
         pipe_id[0]    <= grant_id;
         for (int s = 1; s <= READ_LATENCY; s++) begin
            pipe_valid[s] <= pipe_valid[s-1];
            pipe_id[s]    <= pipe_id[s-1];
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      if (pipe_valid[READ_LATENCY]) rsp_valid[pipe_id[READ_LATENCY]] = 1'b1;
   end

   assign rsp_rdata = sram_dout0;

`ifdef SRAM_ARB_PERF_CNT_EN
   logic conflict;
   assign conflict = ($countones(req_valid) > 1);

   always_ff @(posedge clk0 or posedge rst0) begin
      if (rst0) begin
         perf_grant_cnt    <= '0;
         perf_conflict_cnt <= '0;
      end else begin
         if (grant_any && (perf_grant_cnt != 32'hFFFF_FFFF))
            perf_grant_cnt <= perf_grant_cnt + 32'd1;
         if (conflict && (perf_conflict_cnt != 32'hFFFF_FFFF))
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
   end
`endif

endmodule
